fpu_sp_addsub_arbiter: RTL
==========================

FPU_SP_ADDSUB_ARBITER -- requirements
Module: fpu_sp_addsub_arbiter

Interface
REQ-001 SHALL have ports; clock and reset first:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a  input  32  requester 0 operand A, IEEE-754 single precision.
- req0_b  input  32  requester 0 operand B, IEEE-754 single precision.
- req0_op  input  1  requester 0 operation: 0 = A+B, 1 = A-B.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: as requester 0, for requester 1.
- res_valid  output  1  result held and valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  32  single-precision result.
- res_flag  output  1  overflow/underflow flag from the shared unit.
- res_id  output  1  index of the requester that owns the result.
- busy  output  1  high whenever state is not IDLE.

REQ-002 SHALL contain exactly one internal instance of fpu_sp_subtractor as the shared arithmetic resource.

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-004 In IDLE with no requester valid, SHALL remain in IDLE.
REQ-005 In IDLE with at least one requester valid, SHALL grant one requester.
- reqN_ready SHALL be high combinationally for the granted N only, in that cycle.
- SHALL latch the granted requester's a, b, op and id into operand registers.
- SHALL go to EXEC.
REQ-006 reqN_ready SHALL be low in EXEC and HOLD, and low for any requester that is not granted.
REQ-007 The shared unit SHALL be driven from the operand registers.
- op=1: a and b SHALL be passed unchanged.
- op=0: b SHALL be passed with bit 31 inverted, so that A+B is computed as A-(-B).
REQ-008 In EXEC, SHALL register the unit result into res_data and res_flag and the latched id into res_id.
- SHALL set res_valid=1.
- SHALL go to HOLD.
REQ-009 In HOLD, res_valid, res_data, res_flag and res_id SHALL stay stable until res_ready=1.
- On the handshake cycle (res_valid & res_ready), SHALL clear res_valid on the next edge and go to IDLE.
REQ-010 Timing and throughput:
- Latency: acceptance in cycle N gives res_valid=1 from cycle N+2.
- Minimum spacing between acceptances is 3 cycles when res_ready is held high.
REQ-011 Arbitration SHALL be round-robin with a 1-bit last_grant register, updated on every grant.
- Single valid requester: that requester SHALL win.
- Both valid: the requester not equal to last_grant SHALL win.
REQ-012 Requesters SHALL hold reqN_valid and their operands stable until reqN_ready. The block samples operands only in the grant cycle.
REQ-013 A res_ready asserted while res_valid=0 SHALL have no effect.
REQ-014 A requester's valid arriving in EXEC or HOLD SHALL wait; no request SHALL be lost or duplicated.

Reset
REQ-015 With rst_n=0 at a rising edge, the block SHALL set:
- state = IDLE
- res_valid = 0
- res_data = 0
- res_flag = 0
- res_id = 0
- last_grant = 1, so requester 0 wins first
- operand registers = 0
REQ-016 Reset in EXEC or HOLD SHALL discard the operation in progress, and the block SHALL not deliver a result for it.
REQ-017 reqN_ready SHALL be 0 while rst_n=0.

Configuration
REQ-018 Macro FPU_ARB_FIXED_PRIORITY_EN:
- Defined: requester 0 SHALL always win when both are valid, and last_grant is unused.
- Undefined: round-robin per REQ-011.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Single op: req0 a=0x40400000 (3.0), b=0x3F800000 (1.0), op=1, res_ready=1. Expect req0_ready in cycle 0, res_valid in cycle 2, res_data=0x40000000, res_id=0.
- Add path: req1 a=0x40400000, b=0x3F800000, op=0. Expect res_data=0x40800000 (4.0), res_id=1.
- Contention: both valid continuously after reset. Expect grants in order 0,1,0,1; with FPU_ARB_FIXED_PRIORITY_EN defined, 0,0,0,0.
- Backpressure: res_ready=0 for 5 cycles after res_valid. Expect outputs stable, busy=1, both ready low; res_ready=1 then gives IDLE next cycle.
- Reset mid-op: rst_n=0 in EXEC. Expect res_valid=0 and state IDLE after the edge, and no result delivered.
- Late request: req1 asserted during HOLD of a req0 operation. Expect req1 granted in the first IDLE cycle, exactly once.

Source files
------------

// File: rtl/fpu_sp_addsub_arbiter.sv
// Two-requester arbiter sharing one single-precision subtractor (A+B done as A-(-B)).
// Optional FPU_ARB_FIXED_PRIORITY_EN: requester 0 always wins contention instead of round-robin.

module fpu_sp_subtractor (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        flag
);
    logic              sa, sb, sx, sy, a_nan, b_nan, a_inf, b_inf, rnd, carry;
    logic [7:0]        ea, eb, ex, ey, d;
    logic [23:0]       ma, mb, mx, my;
    logic [55:0]       wide;
    logic [26:0]       xa, ya, nrm;
    logic [27:0]       sum;
    logic [22:0]       frac;
    logic [4:0]        lz;
    logic signed [9:0] en;

    assign sa    = a[31];
    assign sb    = ~b[31];
    assign ea    = a[30:23];
    assign eb    = b[30:23];
    // subnormal inputs are flushed to zero
    assign ma    = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
    assign mb    = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};
    assign a_nan = (&ea) & (|a[22:0]);
    assign b_nan = (&eb) & (|b[22:0]);
    assign a_inf = (&ea) & ~(|a[22:0]);
    assign b_inf = (&eb) & ~(|b[22:0]);

    always_comb begin
        if ({ea, ma} >= {eb, mb}) begin
            sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
        end else begin
            sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
        end
        d    = ex - ey;
        wide = {my, 32'd0} >> d;
        xa   = {mx, 3'b000};
        // [26:3] significand, [2] guard, [1] round, [0] sticky
        ya   = (d > 8'd31) ? {26'd0, |my} : {wide[55:30], |wide[29:0]};
        sum  = (sx == sy) ? ({1'b0, xa} + {1'b0, ya}) : ({1'b0, xa} - {1'b0, ya});
        lz   = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            en  = $signed({2'b00, ex}) + 10'sd1;
        end else begin
            nrm = sum[26:0] << lz;
            en  = $signed({2'b00, ex}) - $signed({5'd0, lz});
        end
        rnd           = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        {carry, frac} = {1'b0, nrm[25:3]} + 24'(rnd);
        if (carry) en = en + 10'sd1;

        flag = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            y = 32'h7FC0_0000;
        else if (a_inf)
            y = a;
        else if (b_inf)
            y = {sb, 8'hFF, 23'd0};
        else if (!nrm[26])
            y = 32'd0;
        else if (en >= 10'sd255) begin
            y = {sx, 8'hFF, 23'd0}; flag = 1'b1;
        end else if (en <= 10'sd0) begin
            y = {sx, 31'd0}; flag = 1'b1;
        end else
            y = {sx, en[7:0], frac};
    end
endmodule

module fpu_sp_addsub_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_op,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_flag,
    output logic        res_id,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t      state, state_nxt;
    logic        grant, gnt_id, op_op, op_id, sub_flag;
    logic [31:0] op_a, op_b, sub_b, sub_y;

`ifdef FPU_ARB_FIXED_PRIORITY_EN
    assign gnt_id = ~req0_valid;
`else
    logic last_grant;
    assign gnt_id = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    always_ff @(posedge clk) begin
        if (!rst_n)     last_grant <= 1'b1;
        else if (grant) last_grant <= gnt_id;
    end
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: if (req0_valid || req1_valid) begin
                grant     = rst_n;
                state_nxt = EXEC;
            end
            EXEC:    state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req0_ready = grant & ~gnt_id;
    assign req1_ready = grant & gnt_id;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    assign sub_b = op_op ? op_b : {~op_b[31], op_b[30:0]};

    fpu_sp_subtractor u_sub (
        .a    (op_a),
        .b    (sub_b),
        .y    (sub_y),
        .flag (sub_flag)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a <= 32'd0; op_b <= 32'd0; op_op <= 1'b0; op_id <= 1'b0;
            res_valid <= 1'b0; res_data <= 32'd0; res_flag <= 1'b0; res_id <= 1'b0;
        end else begin
            if (grant) begin
                op_a  <= gnt_id ? req1_a  : req0_a;
                op_b  <= gnt_id ? req1_b  : req0_b;
                op_op <= gnt_id ? req1_op : req0_op;
                op_id <= gnt_id;
            end
            if (state == EXEC) begin
                res_data  <= sub_y;
                res_flag  <= sub_flag;
                res_id    <= op_id;
                res_valid <= 1'b1;
            end else if (state == HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule
